ov7670_sccb_sender: RTL



---
 rtl/ov7670_sccb_sender_if.sv | 22 ++
 rtl/ov7670_sccb_sender.sv | 109 ++++++++++
 2 files changed

// File: rtl/ov7670_sccb_sender_if.sv
// Command/handshake and SCCB pin bundle between the register table and the sender.
// The table side uses master and the sender uses slave.
interface ov7670_sccb_sender_if;
  logic        send;
  logic [15:0] command;
  logic        finished;
  logic        taken;
  logic        busy;
  logic        sioc;
  logic        siod_o;
  logic        siod_oe;

  modport master (
    output send, command, finished,
    input  taken, busy, sioc, siod_o, siod_oe
  );

  modport slave (
    input  send, command, finished,
    output taken, busy, sioc, siod_o, siod_oe
  );
endinterface

// File: rtl/ov7670_sccb_sender.sv
// Serialises {reg_addr, value} commands into 3-phase SCCB writes (START, 27 bits, STOP).
// All pin outputs are registered and are loaded with the value for the quarter being entered.
module ov7670_sccb_sender #(
  parameter int         CLK_DIV   = 250,
  parameter logic [7:0] DEVICE_ID = 8'h42
) (
  input logic                  clk,
  input logic                  rst,
  ov7670_sccb_sender_if.slave  bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, START, BITS, STOP} state_t;

  state_t           state;
  logic [1:0]       quarter;
  logic [4:0]       bit_idx;
  logic [DIV_W-1:0] div;
  logic [26:0]      shreg;
  logic             tick;

  assign tick = (div == DIV_W'(CLK_DIV - 1));

  // Bits 8, 17 and 26 are the slave's ACK/don't-care slots; the line is released there.
  function automatic logic ack_slot(input logic [4:0] b);
    return (b == 5'd8) || (b == 5'd17) || (b == 5'd26);
  endfunction

  // NOTE: the shift register is reset too; it is only 27 flops and keeps simulation X-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      quarter     <= '0;
      bit_idx     <= '0;
      div         <= '0;
      shreg       <= '0;
      bus.taken   <= 1'b0;
      bus.busy    <= 1'b0;
      bus.sioc    <= 1'b1;
      bus.siod_o  <= 1'b1;
      bus.siod_oe <= 1'b1;
    end else begin
      // NOTE: non-blocking throughout, so every branch sees the pre-edge state.
      bus.taken <= 1'b0;
      if (state == IDLE) begin
        if (bus.send && !bus.finished) begin
          shreg       <= {DEVICE_ID, 1'b1, bus.command[15:8], 1'b1, bus.command[7:0], 1'b1};
          div         <= '0;
          quarter     <= '0;
          bit_idx     <= '0;
          state       <= START;
          bus.taken   <= 1'b1;
          bus.busy    <= 1'b1;
          bus.sioc    <= 1'b1;
          bus.siod_o  <= 1'b1;
          bus.siod_oe <= 1'b1;
        end
      end else if (!tick) begin
        div <= div + 1'b1;
      end else begin
        div     <= '0;
        quarter <= quarter + 2'd1;
        case (state)
          START: begin
            if (quarter == 2'd3) begin
              state       <= BITS;
              bit_idx     <= '0;
              bus.sioc    <= 1'b0;
              bus.siod_o  <= shreg[26];
              bus.siod_oe <= 1'b1;
            end else begin
              bus.siod_o <= (quarter == 2'd0);
            end
          end
          BITS: begin
            if (quarter == 2'd3) begin
              shreg    <= {shreg[25:0], 1'b0};
              bus.sioc <= 1'b0;
              if (bit_idx == 5'd26) begin
                state       <= STOP;
                bus.siod_o  <= 1'b0;
                bus.siod_oe <= 1'b1;
              end else begin
                bit_idx     <= bit_idx + 5'd1;
                bus.siod_o  <= shreg[25];
                bus.siod_oe <= !ack_slot(bit_idx + 5'd1);
              end
            end else begin
              bus.sioc <= (quarter != 2'd0);
            end
          end
          STOP: begin
            bus.sioc <= 1'b1;
            if (quarter == 2'd3) begin
              state      <= IDLE;
              bus.busy   <= 1'b0;
              bus.siod_o <= 1'b1;
            end else begin
              bus.siod_o <= (quarter != 2'd0);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
